// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO controllers: Gray conversion,
// address-width derivation and the pointer reset value.
package fifo_pkg;

    // Conversion functions work on a fixed wide vector; callers zero-extend
    // their pointer in and truncate the result. Leading zeros do not change
    // either conversion, so this stays correct for any pointer width.
    localparam int PTR_MAX_W = 32;

    // Reset value of every read/write pointer (binary and Gray).
    localparam int PTR_RST = 0;

    // Memory address width for a power-of-two depth.
    function automatic int calc_addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-bit flop chain for carrying a Gray-coded pointer into another clock
// domain. Only one bit changes per source update, so per-bit sampling is safe.
module sync_ff_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    // Shift the incoming value through STAGES flops; stage 0 is the metastable one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the asynchronous FIFO (clk_b domain).
// Owns the read pointer, synchronises the write pointer, and produces
// empty / underflow / dout_valid. Optional occupancy output rd_level is
// built only when FIFO_RD_LEVEL_EN is defined.
// rst is assumed to be released synchronously to clk_b by the integrator.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter  int FIFO_DEPTH  = 512,
    parameter  int SYNC_STAGES = 2,
    localparam int ADDR_W      = calc_addr_w(FIFO_DEPTH)
) (
    input  logic              clk_b,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W:0]   wptr_gray_a,
    output logic              r_en,
    output logic [ADDR_W-1:0] r_addr,
    output logic [ADDR_W:0]   rptr_gray,
    output logic              empty,
    output logic              dout_valid,
    output logic              underflow
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR_W:0]   rd_level
`endif
);

    localparam int PTR_W = ADDR_W + 1;

    logic [ADDR_W:0] rptr_bin_q, rptr_bin_d;
    logic [ADDR_W:0] rptr_gray_q, rptr_gray_d;
    logic [ADDR_W:0] wq_gray;
    logic            empty_q, empty_d;
    logic            dout_valid_q;
    logic            underflow_q;

    // Write pointer crosses from clk_a; only the synchronised copy is used below.
    sync_ff_chain #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk (clk_b),
        .rst (rst),
        .d_i (wptr_gray_a),
        .q_o (wq_gray)
    );

    // A read is only issued against the registered (pre-edge) empty flag.
    assign r_en = rd_req & ~empty_q;

    // Next pointer and next empty; empty looks at the post-read pointer so it
    // rises on the same edge that consumes the last word.
    always_comb begin
        rptr_bin_d = rptr_bin_q;
        if (r_en) begin
            rptr_bin_d = rptr_bin_q + PTR_W'(1);
        end
        rptr_gray_d = PTR_W'(bin2gray(PTR_MAX_W'(rptr_bin_d)));
        empty_d     = (rptr_gray_d == wq_gray);
    end

    // Pointer and status registers; reset drops any in-flight dout_valid.
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            rptr_bin_q   <= PTR_W'(PTR_RST);
            rptr_gray_q  <= PTR_W'(PTR_RST);
            empty_q      <= 1'b1;
            dout_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            rptr_bin_q   <= rptr_bin_d;
            rptr_gray_q  <= rptr_gray_d;
            empty_q      <= empty_d;
            dout_valid_q <= r_en;
            underflow_q  <= rd_req & empty_q;
        end
    end

    assign r_addr     = rptr_bin_q[ADDR_W-1:0];
    assign rptr_gray  = rptr_gray_q;
    assign empty      = empty_q;
    assign dout_valid = dout_valid_q;
    assign underflow  = underflow_q;

`ifdef FIFO_RD_LEVEL_EN
    logic [ADDR_W:0] wq_bin;
    logic [ADDR_W:0] rd_level_q;

    assign wq_bin = PTR_W'(gray2bin(PTR_MAX_W'(wq_gray)));

    // Occupancy as seen by the reader; modulo subtraction handles pointer wrap.
    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            rd_level_q <= '0;
        end else begin
            rd_level_q <= wq_bin - rptr_bin_d;
        end
    end

    assign rd_level = rd_level_q;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl (DEPTH=8, SYNC_STAGES=2). Read addresses
// are pushed to a scoreboard when a read is requested and popped when the DUT
// raises r_en. Build with FIFO_RD_LEVEL_EN to also check rd_level.
module tb_fifo_read_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int PW    = 4;

    logic          clk_b = 1'b0;
    logic          rst;
    logic          rd_req;
    logic [PW-1:0] wptr_gray_a;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic [PW-1:0] rptr_gray;
    logic          empty;
    logic          dout_valid;
    logic          underflow;
`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] rd_level;
`endif

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] exp_q[$];
    logic [PW-1:0] m_wptr;
    logic [PW-1:0] m_rptr;

    fifo_read_ctrl #(
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk_b       (clk_b),
        .rst         (rst),
        .rd_req      (rd_req),
        .wptr_gray_a (wptr_gray_a),
        .r_en        (r_en),
        .r_addr      (r_addr),
        .rptr_gray   (rptr_gray),
        .empty       (empty),
        .dout_valid  (dout_valid),
        .underflow   (underflow)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rd_level    (rd_level)
`endif
    );

    always #5 clk_b = ~clk_b;

    function automatic logic [PW-1:0] g(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk_b);
        #2;
    endtask

    task automatic do_write(input int n);
        m_wptr      = m_wptr + PW'(n);
        wptr_gray_a = g(m_wptr);
    endtask

    // Request one read the model says must be accepted; check at the DUT's r_en.
    task automatic do_read(input string tag);
        logic [AW-1:0] e;
        rd_req = 1'b1;
        exp_q.push_back(m_rptr[AW-1:0]);
        #1;
        chk({tag, "_r_en"}, 32'(r_en), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_underrun"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_r_addr"}, 32'(r_addr), 32'(e));
        end
        tick();
        m_rptr = m_rptr + PW'(1);
    endtask

    initial begin
        rst         = 1'b1;
        rd_req      = 1'b0;
        wptr_gray_a = '0;
        m_wptr      = '0;
        m_rptr      = '0;

        // Reset state
        #3;
        chk("rst_empty",      32'(empty),      32'd1);
        chk("rst_r_addr",     32'(r_addr),     32'd0);
        chk("rst_rptr_gray",  32'(rptr_gray),  32'd0);
        chk("rst_dout_valid", 32'(dout_valid), 32'd0);
        chk("rst_underflow",  32'(underflow),  32'd0);
        chk("rst_r_en",       32'(r_en),       32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // T2: empty falls exactly 3 edges after a write-pointer change
        do_write(1);
        tick();
        chk("t2_e1_empty", 32'(empty), 32'd1);
        chk("t2_e1_r_en",  32'(r_en),  32'd0);
        tick();
        chk("t2_e2_empty", 32'(empty), 32'd1);
        chk("t2_e2_r_en",  32'(r_en),  32'd0);
        tick();
        chk("t2_e3_empty", 32'(empty), 32'd0);

        // T3: read of the only word
        do_read("t3");
        rd_req = 1'b0;
        chk("t3_empty",      32'(empty),      32'd1);
        chk("t3_dout_valid", 32'(dout_valid), 32'd1);
        chk("t3_rptr_gray",  32'(rptr_gray),  32'(g(m_rptr)));
        tick();
        chk("t3_dv_drop",    32'(dout_valid), 32'd0);

        // T1: reset mid-stream with a read in flight
        do_write(3);
        tick(); tick(); tick();
        chk("t1_pre_empty", 32'(empty), 32'd0);
        rd_req = 1'b1;
        exp_q.push_back(m_rptr[AW-1:0]);
        #1;
        chk("t1_r_en",   32'(r_en),   32'd1);
        chk("t1_r_addr", 32'(r_addr), 32'(exp_q.pop_front()));
        tick();
        chk("t1_pre_dv", 32'(dout_valid), 32'd1);
        rst         = 1'b1;
        rd_req      = 1'b0;
        wptr_gray_a = '0;
        m_wptr      = '0;
        m_rptr      = '0;
        #1;
        chk("t1_empty",      32'(empty),      32'd1);
        chk("t1_r_addr0",    32'(r_addr),     32'd0);
        chk("t1_rptr_gray",  32'(rptr_gray),  32'd0);
        chk("t1_dout_valid", 32'(dout_valid), 32'd0);
        #3;
        rst = 1'b0;
        tick();

        // T4: 8 writes + 8 reads, twice, across the pointer wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                tick();
                do_write(1);
            end
            tick(); tick(); tick();
            for (int i = 0; i < DEPTH; i++) begin
                do_read($sformatf("t4_r%0d_i%0d", r, i));
            end
            rd_req = 1'b0;
            chk($sformatf("t4_r%0d_empty", r),     32'(empty),      32'd1);
            chk($sformatf("t4_r%0d_rptr_gray", r), 32'(rptr_gray),  32'(g(m_rptr)));
            chk($sformatf("t4_r%0d_dv", r),        32'(dout_valid), 32'd1);
        end
        chk("t4_rptr_wrapped", 32'(rptr_gray), 32'd0);

        // T5: underflow for 3 cycles, pointer frozen
        tick();
        rd_req = 1'b1;
        #1;
        chk("t5_r_en", 32'(r_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_uf%0d", i),    32'(underflow), 32'd1);
            chk($sformatf("t5_rptr%0d", i),  32'(rptr_gray), 32'(g(m_rptr)));
            chk($sformatf("t5_empty%0d", i), 32'(empty),     32'd1);
        end
        rd_req = 1'b0;
        tick();
        chk("t5_uf_clear", 32'(underflow), 32'd0);

        // T6: occupancy after 5 writes and 2 reads
        do_write(5);
        tick(); tick(); tick();
        chk("t6_empty", 32'(empty), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
        chk("t6_level5", 32'(rd_level), 32'(PW'(m_wptr - m_rptr)));
`endif
        do_read("t6_a");
        do_read("t6_b");
        rd_req = 1'b0;
        chk("t6_empty_after", 32'(empty), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
        chk("t6_level3", 32'(rd_level), 32'(PW'(m_wptr - m_rptr)));
`endif
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
